mem_mfc_responder: RTL and testbench

//  Memory-side responder of the CPU MFA/MFC handshake. Accepts word/byte read and

---
 rtl/mem_mfc_responder_if.sv | 26 ++
 rtl/mem_mfc_responder.sv | 128 ++++++++++++
 tb/tb_mem_mfc_responder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mem_mfc_responder_if.sv
// MFA/MFC handshake bundle between the control unit (master) and the memory
// responder (slave). AlignErr is present only when MEM_ALIGN_CHECK_EN is defined.
interface mem_mfc_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  MFA;
  logic                  READ_WRITE;
  logic                  WORD_BYTE;
  logic [ADDR_WIDTH-1:0] Address;
  logic [31:0]           DataIn;
  logic [31:0]           DataOut;
  logic                  MFC;
`ifdef MEM_ALIGN_CHECK_EN
  logic                  AlignErr;

  modport master (output MFA, READ_WRITE, WORD_BYTE, Address, DataIn,
                  input  DataOut, MFC, AlignErr);
  modport slave  (input  MFA, READ_WRITE, WORD_BYTE, Address, DataIn,
                  output DataOut, MFC, AlignErr);
`else
  modport master (output MFA, READ_WRITE, WORD_BYTE, Address, DataIn,
                  input  DataOut, MFC);
  modport slave  (input  MFA, READ_WRITE, WORD_BYTE, Address, DataIn,
                  output DataOut, MFC);
`endif
endinterface

// File: rtl/mem_mfc_responder.sv
// Memory-side responder of the MFA/MFC handshake: byte-addressed RAM with a
// fixed access latency, big-endian word accesses wrapping at the top address.
// Optional feature macro: MEM_ALIGN_CHECK_EN (unaligned word accesses complete
// the handshake, leave memory untouched, read back all-ones and raise AlignErr).
module mem_mfc_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 3
) (
  input  logic      Clk,
  input  logic      Reset,
  mem_mfc_if.slave  bus
);
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q;
  logic                  cap_rw, cap_wb;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [31:0]           cap_data;
  logic                  mfc_q;
  logic [31:0]           dout_q;
  logic                  capture, access;
  logic                  misalign;
  logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;

  // Storage is deliberately left out of reset so contents survive Reset.
  logic [7:0] mem [DEPTH];

  assign a0 = cap_addr;
  assign a1 = cap_addr + ADDR_WIDTH'(1);
  assign a2 = cap_addr + ADDR_WIDTH'(2);
  assign a3 = cap_addr + ADDR_WIDTH'(3);

`ifdef MEM_ALIGN_CHECK_EN
  logic aerr_q;
  assign misalign     = cap_wb && (cap_addr[1:0] != 2'b00);
  assign bus.AlignErr = aerr_q;
`else
  assign misalign = 1'b0;
`endif

  assign bus.MFC     = mfc_q;
  assign bus.DataOut = dout_q;

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode plus the one-cycle capture/access strobes.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: if (bus.MFA) begin
        capture = 1'b1;
        state_d = BUSY;
      end
      BUSY: if (cnt_q == '0) begin
        access  = 1'b1;
        state_d = DONE;
      end
      DONE: if (!bus.MFA) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, latency countdown, MFC and read-data registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q    <= '0;
      cap_rw   <= 1'b0;
      cap_wb   <= 1'b0;
      cap_addr <= '0;
      cap_data <= '0;
      mfc_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      if (capture) begin
        cnt_q    <= CW'(LATENCY - 1);
        cap_rw   <= bus.READ_WRITE;
        cap_wb   <= bus.WORD_BYTE;
        cap_addr <= bus.Address;
        cap_data <= bus.DataIn;
      end else if (state_q == BUSY && cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
      end
      if (access) begin
        mfc_q <= 1'b1;
        if (cap_rw) begin
          if (misalign)    dout_q <= 32'hFFFF_FFFF;
          else if (cap_wb) dout_q <= {mem[a0], mem[a1], mem[a2], mem[a3]};
          else             dout_q <= {24'h0, mem[a0]};
        end
      end else if (state_q == DONE && !bus.MFA) begin
        mfc_q <= 1'b0;
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  // Alignment flag follows MFC for flagged accesses.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                                aerr_q <= 1'b0;
    else if (access)                          aerr_q <= misalign;
    else if (state_q == DONE && !bus.MFA)     aerr_q <= 1'b0;
  end
`endif

  // Memory write, committed on the same edge MFC rises.
  always_ff @(posedge Clk) begin
    if (access && !cap_rw && !misalign) begin
      if (cap_wb) begin
        mem[a0] <= cap_data[31:24];
        mem[a1] <= cap_data[23:16];
        mem[a2] <= cap_data[15:8];
        mem[a3] <= cap_data[7:0];
      end else begin
        mem[a0] <= cap_data[7:0];
      end
    end
  end
endmodule

// File: tb/tb_mem_mfc_responder.sv
// Self-checking bench for mem_mfc_responder: directed table, reset-abort and
// hold sequences, then randomized traffic against a byte-array reference model.
module tb_mem_mfc_responder;
  localparam int AW  = 8;
  localparam int LAT = 3;

  logic Clk, Reset;
  int   checks = 0;
  int   errors = 0;

  mem_mfc_if #(.ADDR_WIDTH(AW)) bus ();

  mem_mfc_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: plain byte array plus last read value.
  logic [7:0]  mref [256];
  logic [31:0] last_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_access(input logic rw, input logic wb, input logic [7:0] a,
                              input logic [31:0] d, output logic [31:0] edout,
                              output logic eaerr);
    logic mis;
`ifdef MEM_ALIGN_CHECK_EN
    mis = wb && (a[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    eaerr = mis;
    if (rw) begin
      if (mis)     last_rd = 32'hFFFF_FFFF;
      else if (wb) last_rd = {mref[int'(a)], mref[(int'(a)+1)%256],
                              mref[(int'(a)+2)%256], mref[(int'(a)+3)%256]};
      else         last_rd = {24'h0, mref[int'(a)]};
    end else if (!mis) begin
      if (wb) for (int k = 0; k < 4; k++) mref[(int'(a)+k)%256] = d[31-8*k -: 8];
      else    mref[int'(a)] = d[7:0];
    end
    edout = last_rd;
  endtask

  // One full handshake; inputs scrambled after capture, MFA held `hold` extra cycles.
  task automatic txn(input logic rw, input logic wb, input logic [7:0] a,
                     input logic [31:0] d, input int hold,
                     output logic [31:0] dout, output logic aerr);
    int   edges;
    logic stay;
    @(negedge Clk);
    bus.MFA = 1'b1; bus.READ_WRITE = rw; bus.WORD_BYTE = wb;
    bus.Address = a; bus.DataIn = d;
    edges = 0;
    @(posedge Clk); #1; edges++;
    bus.READ_WRITE = ~rw; bus.WORD_BYTE = ~wb;
    bus.Address = 8'($urandom); bus.DataIn = $urandom;
    while (!bus.MFC && edges < 40) begin
      @(posedge Clk); #1; edges++;
    end
    chk("mfc_latency_edges", 32'(edges), 32'(LAT + 1));
    dout = bus.DataOut;
`ifdef MEM_ALIGN_CHECK_EN
    aerr = bus.AlignErr;
`else
    aerr = 1'b0;
`endif
    stay = 1'b1;
    repeat (hold) begin
      @(posedge Clk); #1;
      if (!bus.MFC || bus.DataOut !== dout) stay = 1'b0;
    end
    if (hold > 0) chk("mfc_held_stable", 32'(stay), 32'd1);
    @(negedge Clk); bus.MFA = 1'b0;
    @(posedge Clk); #1;
    chk("mfc_fall", 32'(bus.MFC), 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
    chk("alignerr_clear", 32'(bus.AlignErr), 32'd0);
`endif
  endtask

  typedef struct {
    logic        rw;
    logic        wb;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_dout;
    logic        exp_aerr;
  } vec_t;

  initial begin
    vec_t        tbl[$];
    logic [31:0] dout, edout;
    logic        aerr, eaerr;
    logic [31:0] w;

    // Directed vectors (rw, wb, addr, data, expected DataOut, expected AlignErr).
    tbl.push_back('{1'b0, 1'b1, 8'h20, 32'h1234_5678, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h20, 32'h0,         32'h1234_5678, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h21, 32'h0,         32'h0000_0034, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'h23, 32'hFFFF_FFAB, 32'h0000_0034, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h20, 32'h0,         32'h1234_56AB, 1'b0});
`ifdef MEM_ALIGN_CHECK_EN
    tbl.push_back('{1'b1, 1'b1, 8'h21, 32'h0,         32'hFFFF_FFFF, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 8'h22, 32'h9999_9999, 32'hFFFF_FFFF, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 8'h20, 32'h0,         32'h1234_56AB, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h21, 32'h0,         32'h0000_0034, 1'b0});
`else
    tbl.push_back('{1'b0, 1'b1, 8'hFE, 32'hCAFE_F00D, 32'h1234_56AB, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'hFE, 32'h0,         32'h0000_00CA, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'hFF, 32'h0,         32'h0000_00FE, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h00, 32'h0,         32'h0000_00F0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h01, 32'h0,         32'h0000_000D, 1'b0});
`endif

    // Reset state.
    Reset = 1'b1; bus.MFA = 1'b0; bus.READ_WRITE = 1'b0; bus.WORD_BYTE = 1'b0;
    bus.Address = '0; bus.DataIn = '0;
    last_rd = 32'h0;
    #12;
    chk("reset_mfc", 32'(bus.MFC), 32'd0);
    chk("reset_dataout", bus.DataOut, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
    chk("reset_alignerr", 32'(bus.AlignErr), 32'd0);
`endif
    @(negedge Clk); Reset = 1'b0;

    // Fill the whole RAM with a known pattern so the model covers every byte.
    for (int i = 0; i < 64; i++) begin
      for (int k = 0; k < 4; k++) w[31-8*k -: 8] = 8'((4*i + k) * 7 + 3);
      model_access(1'b0, 1'b1, 8'(4*i), w, edout, eaerr);
      txn(1'b0, 1'b1, 8'(4*i), w, 0, dout, aerr);
    end
    chk("dataout_after_writes", dout, 32'h0);

    // Directed table.
    foreach (tbl[i]) begin
      model_access(tbl[i].rw, tbl[i].wb, tbl[i].addr, tbl[i].data, edout, eaerr);
      txn(tbl[i].rw, tbl[i].wb, tbl[i].addr, tbl[i].data, 0, dout, aerr);
      chk($sformatf("vec%0d_dataout", i), dout, tbl[i].exp_dout);
`ifdef MEM_ALIGN_CHECK_EN
      chk($sformatf("vec%0d_alignerr", i), 32'(aerr), 32'(tbl[i].exp_aerr));
`endif
    end

    // Reset in the middle of a word write: access aborted, write dropped.
    @(negedge Clk);
    bus.MFA = 1'b1; bus.READ_WRITE = 1'b0; bus.WORD_BYTE = 1'b1;
    bus.Address = 8'h10; bus.DataIn = 32'hDEAD_BEEF;
    @(posedge Clk); @(posedge Clk); #2;
    Reset = 1'b1; #1;
    chk("abort_mfc", 32'(bus.MFC), 32'd0);
    chk("abort_dataout", bus.DataOut, 32'h0);
    bus.MFA = 1'b0;
    @(negedge Clk); Reset = 1'b0;
    last_rd = 32'h0;
    model_access(1'b1, 1'b1, 8'h10, 32'h0, edout, eaerr);
    txn(1'b1, 1'b1, 8'h10, 32'h0, 0, dout, aerr);
    chk("abort_readback", dout, edout);

    // MFA held 5 cycles past MFC: one access only, MFC stays up.
    model_access(1'b0, 1'b0, 8'h30, 32'h55, edout, eaerr);
    txn(1'b0, 1'b0, 8'h30, 32'h55, 5, dout, aerr);
    model_access(1'b1, 1'b1, 8'h30, 32'h0, edout, eaerr);
    txn(1'b1, 1'b1, 8'h30, 32'h0, 5, dout, aerr);
    chk("hold_readback", dout, edout);

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      logic        rw, wb;
      logic [7:0]  a;
      logic [31:0] d;
      int          h;
      rw = 1'($urandom); wb = 1'($urandom); a = 8'($urandom); d = $urandom;
      h  = $urandom_range(0, 3);
      model_access(rw, wb, a, d, edout, eaerr);
      txn(rw, wb, a, d, h, dout, aerr);
      chk($sformatf("rnd%0d_dataout", n), dout, edout);
`ifdef MEM_ALIGN_CHECK_EN
      chk($sformatf("rnd%0d_alignerr", n), 32'(aerr), 32'(eaerr));
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
